// File: rtl/call_request_latch_pkg.sv
// Shared defaults and debounce state encoding for the floor-call request latch.
package call_request_latch_pkg;

    localparam int DEF_N_FLOORS        = 4;
    localparam int DEF_FLOOR_W         = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CNT_W           = 3;

    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } deb_state_e;

endpackage

// File: rtl/call_request_latch_if.sv
// Call-button / request bundle between the controller side (master) and the latch (slave).
interface call_request_latch_if #(
    parameter int N_FLOORS = 4,
    parameter int FLOOR_W  = 2
);
    logic [N_FLOORS-1:0] btn_raw;
    logic                door_open;
    logic [FLOOR_W-1:0]  curr_floor;
    logic [N_FLOORS-1:0] req;
    logic [FLOOR_W:0]    pending_cnt;
    logic [N_FLOORS-1:0] press_pulse;

    modport master (
        output btn_raw, door_open, curr_floor,
        input  req, pending_cnt, press_pulse
    );

    modport slave (
        input  btn_raw, door_open, curr_floor,
        output req, pending_cnt, press_pulse
    );
endinterface

// File: rtl/call_request_latch_debounce.sv
// One call button: 2-flop synchroniser, debounce counter and FSM; accept pulses on a valid new press.
module call_debounce
    import call_request_latch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic accept
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s;

    assign s = sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt holds the number of stable samples seen so far, including the one that
    // left RELEASED/HELD, so the press lands DEBOUNCE_CYCLES edges after s_i rises.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            RELEASED: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = HELD;
                        accept  = 1'b1;
                    end else begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = RELEASED;
                end else if (cnt_q == LAST) begin
                    state_d = HELD;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = RELEASED;
                    end else begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = HELD;
                end else if (cnt_q == LAST) begin
                    state_d = RELEASED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RELEASED;
        endcase
    end

endmodule

// File: rtl/call_request_latch.sv
// Sticky floor-call request register: debounced presses set bits, door open at a floor clears it.
module call_request_latch
    import call_request_latch_pkg::*;
#(
    parameter int N_FLOORS        = DEF_N_FLOORS,
    parameter int FLOOR_W         = DEF_FLOOR_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    call_request_latch_if.slave  bus
);
    logic [N_FLOORS-1:0] accept;
    logic [N_FLOORS-1:0] req_q, req_d;
    logic [N_FLOORS-1:0] press_pulse_q, press_pulse_d;
    logic [FLOOR_W:0]    pending_cnt;

    for (genvar g = 0; g < N_FLOORS; g++) begin : g_deb
        call_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .btn_raw (bus.btn_raw[g]),
            .accept  (accept[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q         <= '0;
            press_pulse_q <= '0;
        end else begin
            req_q         <= req_d;
            press_pulse_q <= press_pulse_d;
        end
    end

    // A call accepted while its door is open is already served, so clear wins.
    always_comb begin
        req_d         = req_q;
        press_pulse_d = '0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (bus.door_open && (bus.curr_floor == FLOOR_W'(i))) begin
                req_d[i] = 1'b0;
            end else if (accept[i]) begin
                req_d[i]         = 1'b1;
                press_pulse_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        pending_cnt = '0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            pending_cnt = pending_cnt + (FLOOR_W + 1)'(req_q[i]);
        end
    end

    assign bus.req         = req_q;
    assign bus.press_pulse = press_pulse_q;
    assign bus.pending_cnt = pending_cnt;

endmodule
